soc_trace_event_collector: RTL and testbench

SOC_TRACE_EVENT_COLLECTOR -- requirements
Module: soc_trace_event_collector

---
 rtl/soc_trace_event_collector.sv | 167 ++++++++++++++++
 tb/tb_soc_trace_event_collector.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_trace_event_collector.sv
// Collects marker events from per-core retire traces into per-core FIFOs and
// serves them round-robin through a single registered output slot.
module soc_trace_event_collector #(
  parameter int NUM_CORES  = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CORES-1:0]    trace_valid,
  input  logic [NUM_CORES*32-1:0] trace_pc,
  input  logic [NUM_CORES*32-1:0] trace_insn,
  input  logic [NUM_CORES-1:0]    trace_wben,
  input  logic [NUM_CORES*5-1:0]  trace_wbreg,
  input  logic [NUM_CORES*32-1:0] trace_wbdata,
  output logic                    ev_valid,
  input  logic                    ev_ready,
  output logic [CW-1:0]           ev_core,
  output logic [11:0]             ev_code,
  output logic [31:0]             ev_r3,
  output logic [31:0]             ev_pc,
  output logic [NUM_CORES-1:0]    term,
  output logic [NUM_CORES-1:0]    overflow,
  output logic                    all_done
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW = 12 + 32 + 32;
  localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

  logic [EW-1:0]        r_mem [NUM_CORES][FIFO_DEPTH];
  logic [AW-1:0]        r_wp  [NUM_CORES];
  logic [AW-1:0]        r_rp  [NUM_CORES];
  logic [AW:0]          r_cnt [NUM_CORES];
  logic [31:0]          r_r3  [NUM_CORES];
  logic [NUM_CORES-1:0] r_term;
  logic [NUM_CORES-1:0] r_overflow;

  logic                 r_ev_valid;
  logic [CW-1:0]        r_ev_core;
  logic [11:0]          r_ev_code;
  logic [31:0]          r_ev_r3;
  logic [31:0]          r_ev_pc;
  logic [CW-1:0]        r_rr;
  logic                 r_all_done;

  logic [11:0]          w_code [NUM_CORES];
  logic [NUM_CORES-1:0] w_mark;
  logic [NUM_CORES-1:0] w_full;
  logic [NUM_CORES-1:0] w_nonempty;
  logic [NUM_CORES-1:0] w_enq;
  logic [NUM_CORES-1:0] w_deq;
  logic [NUM_CORES-1:0] w_r3_wr;
  logic                 w_load;
  logic                 w_grant_any;
  logic [CW-1:0]        w_grant;
  logic [CW-1:0]        w_cand;
  logic [EW-1:0]        w_head;

  function automatic logic [CW-1:0] f_wrap(input int base, input int off);
    int s;
    s = base + off;
    if (s >= NUM_CORES) s = s - NUM_CORES;
    return s[CW-1:0];
  endfunction

  // Output handshake: an event transfers on a cycle where ev_valid and
  // ev_ready are both high; while ev_valid is high and ev_ready is low the
  // ev_* outputs hold. The slot refills in the same cycle it drains.
  assign w_load = !r_ev_valid || ev_ready;

  always_comb begin
    w_grant_any = 1'b0;
    w_grant     = '0;
    w_cand      = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      w_cand = f_wrap(int'(r_rr), k);
      if (!w_grant_any && w_nonempty[w_cand]) begin
        w_grant_any = 1'b1;
        w_grant     = w_cand;
      end
    end
  end

  assign w_head = r_mem[w_grant][r_rp[w_grant]];

  // Markers sample the shadow r3 before any same-cycle writeback lands.
  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      w_code[i]     = trace_insn[32*i+20 +: 12];
      w_mark[i]     = trace_valid[i] && !r_term[i] &&
                      (trace_insn[32*i +: 20] == 20'h00013) && (w_code[i] != 12'h000);
      w_full[i]     = (r_cnt[i] == FULL_CNT);
      w_nonempty[i] = (r_cnt[i] != '0);
      w_enq[i]      = w_mark[i] && !w_full[i];
      w_deq[i]      = w_load && w_grant_any && (w_grant == CW'(i));
      w_r3_wr[i]    = trace_valid[i] && !r_term[i] && trace_wben[i] &&
                      (trace_wbreg[5*i +: 5] == 5'd3);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CORES; i++) begin
      if (w_enq[i]) r_mem[i][r_wp[i]] <= {w_code[i], r_r3[i], trace_pc[32*i +: 32]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        r_wp[i]  <= '0;
        r_rp[i]  <= '0;
        r_cnt[i] <= '0;
        r_r3[i]  <= '0;
      end
      r_term     <= '0;
      r_overflow <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (w_enq[i]) r_wp[i] <= r_wp[i] + 1'b1;
        if (w_deq[i]) r_rp[i] <= r_rp[i] + 1'b1;
        case ({w_enq[i], w_deq[i]})
          2'b10:   r_cnt[i] <= r_cnt[i] + 1'b1;
          2'b01:   r_cnt[i] <= r_cnt[i] - 1'b1;
          default: r_cnt[i] <= r_cnt[i];
        endcase
        if (w_mark[i] && w_full[i]) r_overflow[i] <= 1'b1;
        if (w_mark[i] && (w_code[i] == 12'h001)) r_term[i] <= 1'b1;
        if (w_r3_wr[i]) r_r3[i] <= trace_wbdata[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ev_valid <= 1'b0;
      r_ev_core  <= '0;
      r_ev_code  <= '0;
      r_ev_r3    <= '0;
      r_ev_pc    <= '0;
      r_rr       <= '0;
      r_all_done <= 1'b0;
    end else begin
      if (w_load) begin
        if (w_grant_any) begin
          r_ev_valid <= 1'b1;
          r_ev_core  <= w_grant;
          {r_ev_code, r_ev_r3, r_ev_pc} <= w_head;
          r_rr       <= f_wrap(int'(w_grant), 1);
        end else begin
          r_ev_valid <= 1'b0;
        end
      end
      r_all_done <= (&r_term) && (w_nonempty == '0) && !r_ev_valid;
    end
  end

  assign ev_valid = r_ev_valid;
  assign ev_core  = r_ev_core;
  assign ev_code  = r_ev_code;
  assign ev_r3    = r_ev_r3;
  assign ev_pc    = r_ev_pc;
  assign term     = r_term;
  assign overflow = r_overflow;
  assign all_done = r_all_done;

endmodule

// File: tb/tb_soc_trace_event_collector.sv
// Bench for soc_trace_event_collector: queue-based reference model compared
// every cycle, plus directed scenarios with hand-computed literal checks.
module tb_soc_trace_event_collector;

  localparam int NC    = 4;
  localparam int DEPTH = 4;

  logic              clk;
  logic              rst;
  logic [NC-1:0]     trace_valid;
  logic [NC*32-1:0]  trace_pc;
  logic [NC*32-1:0]  trace_insn;
  logic [NC-1:0]     trace_wben;
  logic [NC*5-1:0]   trace_wbreg;
  logic [NC*32-1:0]  trace_wbdata;
  logic              ev_valid;
  logic              ev_ready;
  logic [1:0]        ev_core;
  logic [11:0]       ev_code;
  logic [31:0]       ev_r3;
  logic [31:0]       ev_pc;
  logic [NC-1:0]     term;
  logic [NC-1:0]     overflow;
  logic              all_done;

  int checks   = 0;
  int failures = 0;

  soc_trace_event_collector #(.NUM_CORES(NC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_insn(trace_insn),
    .trace_wben(trace_wben), .trace_wbreg(trace_wbreg), .trace_wbdata(trace_wbdata),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_core(ev_core), .ev_code(ev_code),
    .ev_r3(ev_r3), .ev_pc(ev_pc), .term(term), .overflow(overflow), .all_done(all_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: per-core expected queues {code, r3, pc}
  logic [75:0]   exp_q [NC][$];
  logic [31:0]   m_r3 [NC];
  logic [NC-1:0] m_term, m_ovf;
  logic          m_valid, m_done, m_done_n;
  logic [75:0]   m_ev;
  int            m_core, m_rr, m_g, m_idx;
  bit            m_full [NC];
  logic [31:0]   m_insn;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NC; i++) begin
        exp_q[i].delete();
        m_r3[i] = '0;
      end
      m_term = '0; m_ovf = '0; m_valid = 1'b0; m_done = 1'b0;
      m_ev = '0; m_core = 0; m_rr = 0;
    end else begin
      m_done_n = (&m_term) && !m_valid;
      for (int i = 0; i < NC; i++) begin
        m_full[i] = (exp_q[i].size() == DEPTH);
        if (exp_q[i].size() != 0) m_done_n = 1'b0;
      end
      if (!m_valid || ev_ready) begin
        m_g = -1;
        for (int k = 0; k < NC; k++) begin
          m_idx = (m_rr + k) % NC;
          if (m_g < 0 && exp_q[m_idx].size() > 0) m_g = m_idx;
        end
        if (m_g >= 0) begin
          m_ev = exp_q[m_g].pop_front();
          m_valid = 1'b1; m_core = m_g; m_rr = (m_g + 1) % NC;
        end else begin
          m_valid = 1'b0;
        end
      end
      for (int i = 0; i < NC; i++) begin
        if (trace_valid[i] && !m_term[i]) begin
          m_insn = trace_insn[32*i +: 32];
          if (m_insn[19:0] == 20'h00013 && m_insn[31:20] != 12'h0) begin
            if (m_full[i]) m_ovf[i] = 1'b1;
            else exp_q[i].push_back({m_insn[31:20], m_r3[i], trace_pc[32*i +: 32]});
            if (m_insn[31:20] == 12'h001) m_term[i] = 1'b1;
          end
          if (trace_wben[i] && trace_wbreg[5*i +: 5] == 5'd3) m_r3[i] = trace_wbdata[32*i +: 32];
        end
      end
      m_done = m_done_n;
    end
  end

  // compare process
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      chk("cmp_valid", 64'(ev_valid), 64'(m_valid));
      if (m_valid) begin
        chk("cmp_core", 64'(ev_core), 64'(m_core));
        chk("cmp_code", 64'(ev_code), 64'(m_ev[75:64]));
        chk("cmp_r3",   64'(ev_r3),   64'(m_ev[63:32]));
        chk("cmp_pc",   64'(ev_pc),   64'(m_ev[31:0]));
      end
      chk("cmp_term", 64'(term), 64'(m_term));
      chk("cmp_ovf",  64'(overflow), 64'(m_ovf));
      chk("cmp_done", 64'(all_done), 64'(m_done));
    end
  end

  // driver tasks
  task automatic clear_inputs();
    trace_valid = '0; trace_pc = '0; trace_insn = '0;
    trace_wben = '0; trace_wbreg = '0; trace_wbdata = '0;
  endtask

  task automatic step();
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic set_marker(input int c, input logic [11:0] code, input logic [31:0] pc);
    trace_valid[c] = 1'b1;
    trace_insn[32*c +: 32] = {code, 20'h00013};
    trace_pc[32*c +: 32] = pc;
  endtask

  task automatic set_r3(input int c, input logic [31:0] d);
    trace_valid[c] = 1'b1;
    trace_wben[c] = 1'b1;
    trace_wbreg[5*c +: 5] = 5'd3;
    trace_wbdata[32*c +: 32] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_ev(input string name, input int core, input logic [11:0] code);
    chk({name, "_valid"}, 64'(ev_valid), 64'd1);
    chk({name, "_core"},  64'(ev_core),  64'(core));
    chk({name, "_code"},  64'(ev_code),  64'(code));
  endtask

  initial begin
    clear_inputs();
    ev_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_valid", 64'(ev_valid), 64'd0);
    chk("rst_core",  64'(ev_core),  64'd0);
    chk("rst_code",  64'(ev_code),  64'd0);
    chk("rst_r3",    64'(ev_r3),    64'd0);
    chk("rst_pc",    64'(ev_pc),    64'd0);
    chk("rst_term",  64'(term),     64'd0);
    chk("rst_ovf",   64'(overflow), 64'd0);
    chk("rst_done",  64'(all_done), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // basic latency and r3 capture
    set_r3(0, 32'h2A); step();
    set_marker(0, 12'h004, 32'h100); step();
    chk("lat_edge_n", 64'(ev_valid), 64'd0);
    step();
    chk_ev("lat", 0, 12'h004);
    chk("lat_r3", 64'(ev_r3), 64'h2A);
    chk("lat_pc", 64'(ev_pc), 64'h100);

    // same-cycle r3 write is not seen by the marker
    set_r3(1, 32'h11); step();
    set_r3(1, 32'h55); set_marker(1, 12'h022, 32'h200); step(); step();
    chk_ev("r3old", 1, 12'h022);
    chk("r3old_r3", 64'(ev_r3), 64'h11);
    set_marker(1, 12'h023, 32'h204); step(); step();
    chk("r3new_r3", 64'(ev_r3), 64'h55);

    // simultaneous markers, round-robin from core 0
    do_reset();
    for (int i = 0; i < NC; i++) set_marker(i, 12'h010 + 12'(i), 32'h400 + 32'(4*i));
    step();
    for (int c = 0; c < NC; c++) begin
      step();
      chk_ev("rr", c, 12'h010 + 12'(c));
    end
    step();
    chk("rr_empty", 64'(ev_valid), 64'd0);

    // back-pressure and overflow on core 2
    do_reset();
    ev_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      set_marker(2, 12'h031 + 12'(k), 32'h500 + 32'(4*k));
      step();
    end
    chk("ovf_flag", 64'(overflow), 64'h4);
    chk_ev("ovf_hold", 2, 12'h031);
    chk("ovf_pc", 64'(ev_pc), 64'h500);
    ev_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      step();
      chk_ev("ovf_drain", 2, 12'h031 + 12'(k));
    end
    step();
    chk("ovf_empty", 64'(ev_valid), 64'd0);
    chk("ovf_sticky", 64'(overflow), 64'h4);

    // exit markers, all_done, post-termination silence
    do_reset();
    for (int i = 0; i < NC; i++) set_marker(i, 12'h001, 32'h600 + 32'(4*i));
    step();
    chk("exit_term", 64'(term), 64'hF);
    chk("exit_done0", 64'(all_done), 64'd0);
    for (int c = 0; c < NC; c++) begin
      step();
      chk_ev("exit_ev", c, 12'h001);
      chk("exit_r3", 64'(ev_r3), 64'd0);
    end
    step();
    chk("exit_drained", 64'(ev_valid), 64'd0);
    chk("exit_done_early", 64'(all_done), 64'd0);
    step();
    chk("exit_done", 64'(all_done), 64'd1);
    for (int i = 0; i < NC; i++) begin
      set_marker(i, 12'h077, 32'h700);
      set_r3(i, 32'hDEAD);
    end
    step(); step(); step();
    chk("post_term_valid", 64'(ev_valid), 64'd0);
    chk("post_term_done", 64'(all_done), 64'd1);

    // asynchronous reset in mid-transfer
    do_reset();
    ev_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      set_marker(0, 12'h040 + 12'(k), 32'h800 + 32'(4*k));
      if (k == 0) set_marker(1, 12'h001, 32'h900);
      step();
    end
    chk("pre_rst_valid", 64'(ev_valid), 64'd1);
    chk("pre_rst_ovf", 64'(overflow), 64'h1);
    chk("pre_rst_term", 64'(term), 64'h2);
    #2;
    rst = 1'b1;
    #1;
    chk("async_valid", 64'(ev_valid), 64'd0);
    chk("async_term", 64'(term), 64'd0);
    chk("async_ovf", 64'(overflow), 64'd0);
    chk("async_done", 64'(all_done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ev_ready = 1'b1;
    set_marker(3, 12'h007, 32'h300); step();
    chk("after_rst_lat", 64'(ev_valid), 64'd0);
    step();
    chk_ev("after_rst", 3, 12'h007);
    chk("after_rst_pc", 64'(ev_pc), 64'h300);
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
